// File: rtl/mdclcg_pkg.sv
// Shared definitions for the modified dual-CLCG generator datapath.
package mdclcg_pkg;

  localparam int unsigned MDCLCG_WORD_W = 32;

  // Packer FSM: discard warm-up bits, then collect bits into words.
  typedef enum logic {
    StWarmup  = 1'b0,
    StCollect = 1'b1
  } pack_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mdclcg_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous clear.
// dout shows the head while non-empty and holds the last shown head once empty.
module mdclcg_sync_fifo import mdclcg_pkg::*; #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      fill
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      fill_q, fill_d;
  logic [WIDTH-1:0] hold_q;
  logic             do_push, do_pop;

  assign empty   = (fill_q == '0);
  assign full    = (fill_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign fill = fill_q;
  assign dout = empty ? hold_q : mem_q[rptr_q];

  // Occupancy: +1 on push, -1 on pop, unchanged when both.
  always_comb begin
    fill_d = fill_q;
    if (do_push && !do_pop) begin
      fill_d = fill_q + 1'b1;
    end else if (do_pop && !do_push) begin
      fill_d = fill_q - 1'b1;
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      fill_q <= fill_d;
    end
  end

  // Storage array; contents past the pointers are don't-care, so no clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

  // Tracks the head being shown so dout freezes on it when the FIFO drains.
  always_ff @(posedge clk) begin
    if (clr) begin
      hold_q <= '0;
    end else if (!empty) begin
      hold_q <= mem_q[rptr_q];
    end
  end

endmodule

// File: rtl/mdclcg_word_packer.sv
// Packs the generator's 1-bit Zi stream MSB-first into words after a warm-up
// skip, buffers them in a FWFT FIFO and counts words lost to overflow.
module mdclcg_word_packer import mdclcg_pkg::*; #(
  parameter int unsigned WORD_W = MDCLCG_WORD_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SKIP   = 0
) (
  input  logic                   clk,
  input  logic                   start,
  input  logic                   zi,
  input  logic                   zi_valid,
  output logic [WORD_W-1:0]      word_data,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic [clog2(DEPTH):0]  fill
);

  localparam int unsigned BCW        = clog2(WORD_W);
  localparam logic [15:0] SkipLast   = (SKIP == 0) ? 16'd0 : 16'(SKIP - 1);
  localparam pack_state_e ResetState = (SKIP == 0) ? StCollect : StWarmup;

  pack_state_e       state_q, state_d;
  logic [15:0]       skip_cnt_q, skip_cnt_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  // Holds the WORD_W-1 bits collected so far; the last bit joins on completion.
  logic [WORD_W-2:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] shifted;
  logic              word_push;

  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              fifo_empty, fifo_full, pop, drop;

  assign shifted = {shreg_q, zi};

  // Next-state for the warm-up/collect FSM, counters and shift register.
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    word_push  = 1'b0;
    if (zi_valid) begin
      case (state_q)
        StWarmup: begin
          skip_cnt_d = skip_cnt_q + 16'd1;
          // The bit that completes the skip is itself discarded.
          if (skip_cnt_q == SkipLast) state_d = StCollect;
        end
        StCollect: begin
          shreg_d = shifted[WORD_W-2:0];
          if (bit_cnt_q == BCW'(WORD_W - 1)) begin
            bit_cnt_d = '0;
            word_push = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: state_d = ResetState;
      endcase
    end
  end

  assign pop  = word_valid && word_ready;
  assign drop = word_push && fifo_full && !pop;

  // Sticky overflow flag and saturating drop counter.
  always_comb begin
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // State registers; start clears everything, overriding any same-cycle event.
  always_ff @(posedge clk) begin
    if (start) begin
      state_q    <= ResetState;
      skip_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  mdclcg_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (start),
    .push  (word_push),
    .din   (shifted),
    .pop   (pop),
    .dout  (word_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .fill  (fill)
  );

  assign word_valid = !fifo_empty;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_mdclcg_word_packer.sv
// Scoreboard bench: two packers (SKIP=0 and SKIP=3) share one input stream;
// a word-level model predicts the emitted words, occupancy and drops.
module tb_mdclcg_word_packer;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b1;
  logic        zi = 1'b0;
  logic        zi_valid = 1'b0;
  logic        word_ready = 1'b0;

  logic [31:0] wd  [2];
  logic        wv  [2];
  logic        ovf [2];
  logic [15:0] dc  [2];
  logic [2:0]  fl  [2];

  mdclcg_word_packer #(.WORD_W(32), .DEPTH(DEPTH), .SKIP(0)) u_dut0 (
    .clk(clk), .start(start), .zi(zi), .zi_valid(zi_valid),
    .word_data(wd[0]), .word_valid(wv[0]), .word_ready(word_ready),
    .overflow(ovf[0]), .drop_cnt(dc[0]), .fill(fl[0])
  );

  mdclcg_word_packer #(.WORD_W(32), .DEPTH(DEPTH), .SKIP(3)) u_dut3 (
    .clk(clk), .start(start), .zi(zi), .zi_valid(zi_valid),
    .word_data(wd[1]), .word_valid(wv[1]), .word_ready(word_ready),
    .overflow(ovf[1]), .drop_cnt(dc[1]), .fill(fl[1])
  );

  // Reference model state, one slot per DUT.
  int          skipv [2] = '{0, 3};
  int          mfill [2];
  int          mdrop [2];
  int          nacc  [2];
  int          nbits [2];
  bit          movf  [2];
  logic [31:0] cur   [2];
  logic [31:0] last_word [2];
  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", name, d, $time, act, expv);
    end
  endtask

  // Model one clock edge from the inputs presented to it.
  task automatic model_edge();
    bit popped, completed;
    for (int d = 0; d < 2; d++) begin
      if (start) begin
        mfill[d] = 0; mdrop[d] = 0; nacc[d] = 0; nbits[d] = 0;
        movf[d] = 1'b0; cur[d] = '0; last_word[d] = '0;
        if (d == 0) exp0.delete(); else exp1.delete();
      end else begin
        popped = word_ready && (mfill[d] > 0);
        completed = 1'b0;
        if (zi_valid) begin
          if (nacc[d] < skipv[d]) begin
            nacc[d]++;
          end else begin
            cur[d] = {cur[d][30:0], zi};
            nbits[d]++;
            if (nbits[d] == 32) begin
              completed = 1'b1;
              nbits[d] = 0;
            end
          end
        end
        if (completed) begin
          if (mfill[d] == DEPTH && !popped) begin
            movf[d] = 1'b1;
            if (mdrop[d] < 65535) mdrop[d]++;
          end else begin
            if (d == 0) exp0.push_back(cur[d]); else exp1.push_back(cur[d]);
            mfill[d]++;
          end
        end
        if (popped) mfill[d]--;
      end
    end
  endtask

  // Monitor: compare status every cycle; compare and retire the head on handshake.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int qs;
        logic [31:0] head;
        qs = (d == 0) ? exp0.size() : exp1.size();
        head = '0;
        if (qs > 0) head = (d == 0) ? exp0[0] : exp1[0];
        chk("fill", d, 32'(fl[d]), 32'(mfill[d]));
        chk("word_valid", d, 32'(wv[d]), 32'(mfill[d] > 0));
        chk("overflow", d, 32'(ovf[d]), 32'(movf[d]));
        chk("drop_cnt", d, 32'(dc[d]), 32'(mdrop[d]));
        if (wv[d]) begin
          if (qs == 0) begin
            chk("unexpected_word", d, 32'(wv[d]), 32'd0);
          end else begin
            chk("word_data", d, wd[d], head);
            if (word_ready && !start) begin
              last_word[d] = head;
              if (d == 0) void'(exp0.pop_front()); else void'(exp1.pop_front());
            end
          end
        end else begin
          chk("word_data_hold", d, wd[d], last_word[d]);
        end
      end
    end
  end

  task automatic step(input logic s, input logic z, input logic v, input logic r);
    start = s; zi = z; zi_valid = v; word_ready = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic r);
    for (int i = 31; i >= 0; i--) step(1'b0, w[i], 1'b1, r);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'b0, r);
  endtask

  initial begin
    logic [31:0] w;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Warm-up skip then a known word.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    send_word(32'h0000FFFF, 1'b0);
    idle(3, 1'b0);

    // Packing/latency, then zi_valid gaps carrying ones on invalid cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(32'hA5A5A5A5, 1'b0);
    idle(2, 1'b0);
    w = 32'h12345678;
    for (int i = 31; i >= 0; i--) begin
      step(1'b0, w[i], 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    // Overflow: six words total without a consumer, then drain.
    for (int k = 0; k < 4; k++) send_word($urandom, 1'b0);
    idle(3, 1'b0);
    idle(12, 1'b1);

    // Full FIFO with a pop in the cycle the fifth word completes.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_word($urandom, 1'b0);
    w = $urandom;
    for (int i = 31; i >= 1; i--) step(1'b0, w[i], 1'b1, 1'b0);
    step(1'b0, w[0], 1'b1, 1'b1);
    idle(3, 1'b0);
    idle(8, 1'b1);

    // Reset mid-word with words buffered.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b0);
    w = $urandom;
    for (int i = 31; i >= 15; i--) step(1'b0, w[i], 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    send_word(32'hDEADBEEF, 1'b0);
    idle(3, 1'b1);

    // Randomized stream with sporadic resets.
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 399) == 0), 1'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    idle(12, 1'b1);
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
